// File: rtl/mult_div_pkg.sv
// mult_div_pkg: op codes, FSM states and shared constants for the multiply/divide unit.
package mult_div_pkg;
  localparam int MUL_CYCLES_DEF = 3;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MADD  = 3'd4,
    MDU_MADDU = 3'd5
  } mdu_op_t;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} mdu_state_t;
  function automatic logic is_div(input mdu_op_t op);
    return op == MDU_DIV || op == MDU_DIVU;
  endfunction
endpackage

// File: rtl/mult_div_div_iter.sv
// div_iter: 32-step radix-2 restoring divider on unsigned magnitudes.
module div_iter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_start,
  input  logic        i_flush,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder,
  output logic        o_done
);
  logic [31:0] r_rem, r_quo, r_div;
  logic [4:0]  r_cnt;
  logic        r_active;
  logic [32:0] w_sh;
  logic [31:0] w_diff;
  logic        w_ge;
  // Dividend bits shift out of the quotient register into the remainder as quotient bits shift in.
  assign w_sh   = {r_rem, r_quo[31]};
  assign w_ge   = w_sh >= {1'b0, r_div};
  assign w_diff = w_sh[31:0] - r_div;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_flush) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_rem    <= '0;
      r_quo    <= i_dividend;
      r_div    <= i_divisor;
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_rem    <= w_ge ? w_diff : w_sh[31:0];
      r_quo    <= {r_quo[30:0], w_ge};
      r_cnt    <= r_cnt + 5'd1;
      r_active <= r_cnt != 5'd31;
    end
  assign o_done      = r_active && r_cnt == 5'd31;
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;
endmodule

// File: rtl/mult_div.sv
// mult_div: multi-cycle MULT/MULTU/DIV/DIVU unit feeding the HI/LO registers.
// Defining MULT_DIV_MADD_EN enables MADD/MADDU accumulation into {HI,LO}.
module mult_div
  import mult_div_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            valid_i,
  input  mdu_op_t         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            hi_write_o,
  output logic            lo_write_o,
  output logic [XLEN-1:0] hi_data_o,
  output logic [XLEN-1:0] lo_data_o
);
  mdu_state_t        r_state, w_next;
  mdu_op_t           r_op;
  logic [XLEN-1:0]   r_a, r_b;
  logic [2:0]        r_cnt;
  logic              w_accept, w_div_start, w_div_done, w_done_st;
  logic [XLEN-1:0]   w_amag, w_bmag, w_quo, w_rem, w_q, w_r, w_hi, w_lo;
  logic              w_dsgn_in, w_msgn, w_q_neg, w_r_neg, w_bz;
  logic [2*XLEN-1:0] w_ax, w_bx, w_prod, w_mres;
  assign ready_o     = r_state == S_IDLE;
  assign busy_o      = !ready_o;
  assign w_accept    = valid_i && ready_o && !flush_i;
  assign w_div_start = w_accept && is_div(op_i);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (flush_i) w_next = S_IDLE;
    else
      case (r_state)
        S_IDLE:  if (w_accept) w_next = is_div(op_i) ? S_DIV : S_MUL;
        S_MUL:   if (r_cnt == 3'(MUL_CYCLES - 1)) w_next = S_DONE;
        S_DIV:   if (w_div_done) w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_op  <= MDU_MULT;
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_op  <= op_i;
      r_a   <= a_i;
      r_b   <= b_i;
      r_cnt <= '0;
    end else if (r_state == S_MUL) begin
      r_cnt <= r_cnt + 3'd1;
    end
  // Sign-extend only for the signed forms; truncating the 64-bit product is exact either way.
  assign w_msgn = r_op == MDU_MULT || r_op == MDU_MADD;
  assign w_ax   = {{XLEN{w_msgn & r_a[XLEN-1]}}, r_a};
  assign w_bx   = {{XLEN{w_msgn & r_b[XLEN-1]}}, r_b};
  assign w_prod = w_ax * w_bx;
`ifdef MULT_DIV_MADD_EN
  logic [2*XLEN-1:0] r_acc;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_acc <= '0;
    else if (w_accept) r_acc <= {hi_i, lo_i};
  assign w_mres = (r_op == MDU_MADD || r_op == MDU_MADDU) ? r_acc + w_prod : w_prod;
`else
  logic w_unused_acc;
  assign w_unused_acc = ^{hi_i, lo_i};
  assign w_mres       = w_prod;
`endif
  assign w_dsgn_in = op_i == MDU_DIV;
  assign w_amag    = (w_dsgn_in && a_i[XLEN-1]) ? -a_i : a_i;
  assign w_bmag    = (w_dsgn_in && b_i[XLEN-1]) ? -b_i : b_i;
  div_iter u_div (
    .clk        (clk),
    .resetn     (resetn),
    .i_start    (w_div_start),
    .i_flush    (flush_i),
    .i_dividend (w_amag),
    .i_divisor  (w_bmag),
    .o_quotient (w_quo),
    .o_remainder(w_rem),
    .o_done     (w_div_done)
  );
  assign w_q_neg   = r_op == MDU_DIV && (r_a[XLEN-1] ^ r_b[XLEN-1]);
  assign w_r_neg   = r_op == MDU_DIV && r_a[XLEN-1];
  assign w_q       = w_q_neg ? -w_quo : w_quo;
  assign w_r       = w_r_neg ? -w_rem : w_rem;
  assign w_bz      = r_b == '0;
  assign w_hi      = is_div(r_op) ? (w_bz ? r_a : w_r) : w_mres[2*XLEN-1:XLEN];
  assign w_lo      = is_div(r_op) ? (w_bz ? DIV_ZERO_Q : w_q) : w_mres[XLEN-1:0];
  assign w_done_st = r_state == S_DONE;
  assign done_o     = w_done_st && !flush_i;
  assign hi_write_o = done_o;
  assign lo_write_o = done_o;
  assign hi_data_o  = w_done_st ? w_hi : '0;
  assign lo_data_o  = w_done_st ? w_lo : '0;
endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: directed self-checking bench for mult_div (MULT_DIV_MADD_EN selects MADD expectations).
module tb_mult_div;
  import mult_div_pkg::*;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid_i = 1'b0;
  mdu_op_t     op_i = MDU_MULT;
  logic [31:0] a_i = '0, b_i = '0, hi_i = '0, lo_i = '0;
  logic        flush_i = 1'b0;
  logic        ready_o, busy_o, done_o, hi_write_o, lo_write_o;
  logic [31:0] hi_data_o, lo_data_o;
  int          n_tests = 0, n_fail = 0;

  mult_div dut (
    .clk       (clk),
    .resetn    (resetn),
    .valid_i   (valid_i),
    .op_i      (op_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .flush_i   (flush_i),
    .hi_i      (hi_i),
    .lo_i      (lo_i),
    .ready_o   (ready_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .hi_write_o(hi_write_o),
    .lo_write_o(lo_write_o),
    .hi_data_o (hi_data_o),
    .lo_data_o (lo_data_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
    valid_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    tick();
    valid_i = 1'b0;
  endtask

  // Issue one op, wait (bounded) for done_o, then check latency, result, strobes and return to idle.
  task automatic run_op(input string tag, input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    issue(op, a, b);
    chk({tag, "_busy_after_accept"}, {62'b0, ready_o, busy_o}, 64'b01);
    lat = 0;
    while (!done_o && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_hilo"}, {hi_data_o, lo_data_o}, {exp_hi, exp_lo});
    chk({tag, "_done_strobes"}, {60'b0, hi_write_o, lo_write_o, busy_o, ready_o}, 64'b1110);
    tick();
    chk({tag, "_idle_after"}, {hi_data_o, lo_data_o[27:0], done_o, hi_write_o, lo_write_o, ready_o},
        {32'b0, 28'b0, 4'b0001});
  endtask

  initial begin
    int nw;
    #1;
    chk("reset_state", {ready_o, busy_o, done_o, hi_write_o, lo_write_o, hi_data_o, lo_data_o},
        {1'b1, 4'b0, 64'b0});
    repeat (2) tick();
    resetn = 1'b1;
    tick();

    run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'd5, 3, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("div_neg7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_neg2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 32, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_1000_7", MDU_DIVU, 32'd1000, 32'd7, 32, 32'd6, 32'd142);
    run_op("divu_by0", MDU_DIVU, 32'd100, 32'd0, 32, 32'h0000_0064, 32'hFFFF_FFFF);
    run_op("div_by0", MDU_DIV, 32'hFFFF_FFF0, 32'd0, 32, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'h0000_0000, 32'h8000_0000);

    issue(MDU_DIV, 32'd1000, 32'd3);
    repeat (9) tick();
    flush_i = 1'b1;
    #1;
    chk("flush_div_no_done", {61'b0, done_o, hi_write_o, lo_write_o}, 64'b0);
    tick();
    flush_i = 1'b0;
    chk("flush_div_ready", {62'b0, ready_o, busy_o}, 64'b10);
    nw = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_o || hi_write_o || lo_write_o) nw++;
    end
    chk("flush_div_no_write", 64'(nw), 64'd0);
    run_op("multu_after_flush", MDU_MULTU, 32'd2, 32'd3, 3, 32'd0, 32'd6);

    issue(MDU_MULTU, 32'd7, 32'd9);
    repeat (3) tick();
    chk("pre_flush_done", {63'b0, done_o}, 64'b1);
    flush_i = 1'b1;
    #1;
    chk("flush_in_done", {61'b0, done_o, hi_write_o, lo_write_o}, 64'b0);
    tick();
    flush_i = 1'b0;
    chk("flush_in_done_idle", {62'b0, ready_o, busy_o}, 64'b10);

    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (5) tick();
    #2;
    resetn = 1'b0;
    #1;
    chk("async_reset_outputs", {ready_o, busy_o, done_o, hi_write_o, lo_write_o, hi_data_o, lo_data_o},
        {1'b1, 4'b0, 64'b0});
    tick();
    resetn = 1'b1;
    nw = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_o || hi_write_o || lo_write_o) nw++;
    end
    chk("reset_no_write", 64'(nw), 64'd0);
    chk("reset_ready", {62'b0, ready_o, busy_o}, 64'b10);

    hi_i = 32'd0;
    lo_i = 32'hFFFF_FFFF;
`ifdef MULT_DIV_MADD_EN
    run_op("maddu_carry", MDU_MADDU, 32'd1, 32'd1, 3, 32'd1, 32'd0);
    run_op("madd_neg", MDU_MADD, 32'hFFFF_FFFF, 32'd1, 3, 32'd0, 32'hFFFF_FFFE);
`else
    run_op("maddu_as_multu", MDU_MADDU, 32'd1, 32'd1, 3, 32'd0, 32'd1);
    run_op("madd_as_mult", MDU_MADD, 32'hFFFF_FFFF, 32'd1, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_div.md
Name: mult_div

Overview:
- Multi-cycle integer multiply/divide unit in the execute stage, directly upstream of the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU from the issue path and iterates for a fixed number of cycles.
- On completion it pulses one cycle of HI/LO write enables and data, which the HI/LO registers latch.
- Stalls the pipeline via `busy_o` and aborts cleanly on pipeline flush.

Parameters:
- MUL_CYCLES, 3, number of clock edges from accept to product ready; range 1..8.
- XLEN, 32, operand width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- valid_i  in  1  operation request.
- op_i  in  3  mdu_op_t: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU (MDU_MADD, MDU_MADDU with the optional feature).
- a_i  in  32  rs operand: multiplicand or dividend.
- b_i  in  32  rt operand: multiplier or divisor.
- flush_i  in  1  abort any in-flight operation.
- hi_i  in  32  current HI value (used only by the optional feature).
- lo_i  in  32  current LO value (used only by the optional feature).
- ready_o  out  1  unit idle, can accept a request.
- busy_o  out  1  operation in flight, including the DONE cycle.
- done_o  out  1  result valid this cycle.
- hi_write_o  out  1  HI write enable.
- lo_write_o  out  1  LO write enable.
- hi_data_o  out  32  data for HI.
- lo_data_o  out  32  data for LO.

Behaviour:
- Clock and reset: single clock `clk`; reset `resetn` is asynchronous, active-low.
- While `resetn` is low:
  - state = IDLE;
  - all counters and operand registers = 0;
  - `ready_o` = 1; `busy_o`, `done_o`, `hi_write_o`, `lo_write_o` = 0; `hi_data_o`, `lo_data_o` = 0.
- Reset asserted mid-operation discards the operation; no write is issued.
- States:
  - IDLE: `ready_o` = 1.
  - MUL: counts to MUL_CYCLES.
  - DIV: 32 iterations.
  - DONE: outputs the result for exactly one cycle.
- Accept: at a rising edge where `valid_i` && `ready_o` && !`flush_i`.
  - Operands and op are latched at that edge (edge 0).
  - `valid_i` outside IDLE is ignored; the upstream stage must hold its request.
- Multiply:
  - 64-bit product computed from the latched operands: signed for MULT, zero-extended for MULTU.
  - Edge MUL_CYCLES moves the unit to DONE.
  - HI = product[63:32], LO = product[31:0].
- Divide, radix-2 restoring:
  - Magnitudes are latched; one quotient bit per edge on edges 1..32; edge 32 moves the unit to DONE.
  - Sign fix in DONE is combinational:
    - quotient is negated if operand signs differ (DIV only);
    - remainder takes the dividend's sign.
  - LO = quotient, HI = remainder.
  - Divisor 0: LO = 0xFFFFFFFF, HI = dividend, for both DIV and DIVU.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- DONE cycle:
  - `done_o` = `hi_write_o` = `lo_write_o` = 1; the next edge returns the unit to IDLE.
  - Outside DONE, write enables are 0 and data outputs are 0.
- Flush:
  - While `flush_i` = 1, `done_o` and the write enables are forced to 0 combinationally.
  - The next edge puts the unit in IDLE from any state.
- Latency from accept edge to `done_o`:
  - multiply: `done_o` visible in the cycle after edge MUL_CYCLES;
  - divide: `done_o` visible in the cycle after edge 32.
- Back-to-back operations: minimum one IDLE cycle between DONE and the next accept.

Optional Feature:
- Macro: MULT_DIV_MADD_EN.
- When defined:
  - MDU_MADD and MDU_MADDU are accepted.
  - {`hi_i`,`lo_i`} is latched at accept, and {HI,LO} = latched value + product, modulo 2^64.
  - Latency is the same as multiply.
- When undefined:
  - those op codes are treated as MULT/MULTU;
  - `hi_i`/`lo_i` remain as ports but are unused.

Decomposition:
- mdu_op_t enum and the MDU_* codes go in the shared pipes package.
- The MUL_CYCLES default and the div-by-zero quotient constant go in the common package.
- One sub-module, div_iter: holds the 32-step restoring divider datapath (partial remainder, quotient shift register, step counter). Ports: start, flush, dividend/divisor magnitudes, quotient/remainder, done.
- Sign handling and the FSM stay in mult_div.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `done_o` in the cycle after edge 3; HI = 0xFFFFFFFE, LO = 0x00000001; both write enables = 1 for exactly one cycle.
- MULT 0xFFFFFFFD (−3) × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1; `ready_o` = 0 until the cycle after DONE.
- DIV 0xFFFFFFF9 (−7) / 2 → `done_o` in the cycle after edge 32; LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- Boundary divides:
  - DIVU 100 / 0 → LO = 0xFFFFFFFF, HI = 0x00000064.
  - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Flush:
  - `flush_i` pulsed at DIV iteration 10 → no `done_o`; `ready_o` = 1 in the next cycle.
  - Then MULTU 2 × 3 → LO = 6, HI = 0.
  - `flush_i` during DONE → write enables are 0 that cycle.
- Reset mid-operation:
  - `resetn` dropped asynchronously mid-DIV → all outputs 0 immediately; `ready_o` = 1; no write after release.
  - With MULT_DIV_MADD_EN defined: `hi_i` = 0, `lo_i` = 0xFFFFFFFF, MADDU 1 × 1 → HI = 1, LO = 0.
